// File: rtl/video_timing.sv
// Purpose : raster timing generator. It produces counters plus delayed active, sync, line and frame strobes.
// Latency : hcount/vcount are undelayed. The strobes lag the counters by DELAY enabled cycles.
// Backpr. : none. When ce=0 the whole block holds its state, so it stalls cleanly.
// Ports   : clk, rst_n (async active-low), ce (pixel enable) -> hcount, vcount,
//           active, hsync, vsync, line, frame
module video_timing #(
   parameter int unsigned HACT  = 640,
   parameter int unsigned HFP   = 16,
   parameter int unsigned HSW   = 96,
   parameter int unsigned HBP   = 48,
   parameter int unsigned VACT  = 480,
   parameter int unsigned VFP   = 10,
   parameter int unsigned VSW   = 2,
   parameter int unsigned VBP   = 33,
   parameter bit          HSPOL = 1'b0,
   parameter bit          VSPOL = 1'b0,
   parameter int unsigned DELAY = 1,
   parameter int unsigned XW    = 10,
   parameter int unsigned YW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce,
   output logic [XW-1:0] hcount,
   output logic [YW-1:0] vcount,
   output logic          active,
   output logic          hsync,
   output logic          vsync,
   output logic          line,
   output logic          frame
);

   localparam int unsigned HTOT = HACT + HFP + HSW + HBP;
   localparam int unsigned VTOT = VACT + VFP + VSW + VBP;

   // Bad geometry is rejected at elaboration time rather than producing a silently wrapped raster.
   if (HACT < 1 || HFP < 1 || HSW < 1 || HBP < 1 ||
       VACT < 1 || VFP < 1 || VSW < 1 || VBP < 1 ||
       DELAY < 1 || DELAY > 8 || XW < 1 || YW < 1 || XW > 31 || YW > 31 ||
       longint'(HTOT) > (longint'(1) << XW) ||
       longint'(VTOT) > (longint'(1) << YW)) begin : g_param_err
      $error("video_timing: illegal parameter combination");
   end

   // Every boundary is strictly below the total, so these constants fit the counter widths.
   localparam logic [XW-1:0] H_LAST = XW'(HTOT - 1);
   localparam logic [XW-1:0] H_ACT  = XW'(HACT);
   localparam logic [XW-1:0] H_SS   = XW'(HACT + HFP);
   localparam logic [XW-1:0] H_SE   = XW'(HACT + HFP + HSW);
   localparam logic [YW-1:0] V_LAST = YW'(VTOT - 1);
   localparam logic [YW-1:0] V_ACT  = YW'(VACT);
   localparam logic [YW-1:0] V_SS   = YW'(VACT + VFP);
   localparam logic [YW-1:0] V_SE   = YW'(VACT + VFP + VSW);

   // Pipeline entries hold positive-logic flags. All-zero is the inactive value for every
   // field, and sync polarity is applied only after the last stage.
   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
      logic ln;
      logic fr;
   } tim_t;

   logic [XW-1:0] hcount_q, hcount_d;
   logic [YW-1:0] vcount_q, vcount_d;
   tim_t          raw;
   tim_t          pipe_q [DELAY];

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (ce) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + YW'(1);
         end else begin
            hcount_d = hcount_q + XW'(1);
         end
      end
   end

   // vcount only moves at the hcount wrap, so vsync naturally changes only at hcount==0.
   always_comb begin
      raw     = '0;
      raw.act = (hcount_q < H_ACT) && (vcount_q < V_ACT);
      raw.hs  = (hcount_q >= H_SS) && (hcount_q < H_SE);
      raw.vs  = (vcount_q >= V_SS) && (vcount_q < V_SE);
      raw.ln  = (hcount_q == '0);
      raw.fr  = (hcount_q == '0) && (vcount_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DELAY); i++) begin
            pipe_q[i] <= '0;
         end
      end else if (ce) begin
         pipe_q[0] <= raw;
         for (int i = 1; i < int'(DELAY); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign hcount = hcount_q;
   assign vcount = vcount_q;
   assign active = pipe_q[DELAY-1].act;
   assign hsync  = pipe_q[DELAY-1].hs ^ ~HSPOL;
   assign vsync  = pipe_q[DELAY-1].vs ^ ~VSPOL;
   assign line   = pipe_q[DELAY-1].ln;
   assign frame  = pipe_q[DELAY-1].fr;

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;

   localparam int HACT = 4, HFP = 1, HSW = 2, HBP = 1;
   localparam int VACT = 3, VFP = 1, VSW = 1, VBP = 1;
   localparam int HT = HACT + HFP + HSW + HBP;
   localparam int VT = VACT + VFP + VSW + VBP;

   logic clk, rst_n, ce;

   logic [9:0] hc1, vc1;
   logic       act1, hs1, vs1, ln1, fr1;
   logic [3:0] hc2;
   logic [2:0] vc2;
   logic       act2, hs2, vs2, ln2, fr2;

   video_timing #(
      .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
      .HSPOL(1'b0), .VSPOL(1'b0), .DELAY(2), .XW(10), .YW(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(hc1), .vcount(vc1), .active(act1), .hsync(hs1),
      .vsync(vs1), .line(ln1), .frame(fr1)
   );

   video_timing #(
      .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
      .HSPOL(1'b1), .VSPOL(1'b1), .DELAY(1), .XW(4), .YW(3)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(hc2), .vcount(vc2), .active(act2), .hsync(hs2),
      .vsync(vs2), .line(ln2), .frame(fr2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int n        = 0;   // enabled cycles since reset release
   logic chk_en = 1'b0;
   logic ce_last = 1'b1;

   logic [24:0] obs1, obs2, prev1, prev2;
   logic        prev_ok = 1'b0;
   assign obs1 = {hc1, vc1, act1, hs1, vs1, ln1, fr1};
   assign obs2 = {6'b0, hc2, 7'b0, vc2, act2, hs2, vs2, ln2, fr2};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  n <= 0;
      else if (ce) n <= n + 1;
   end

   always @(posedge clk) ce_last <= ce;

   // Expected strobes {active,hsync,vsync,line,frame} after k enabled cycles, for latency d.
   function automatic logic [4:0] model_sig(int k, int d, bit hp, bit vp);
      int  m, h, v;
      bit  a, hs, vs, ln, fr;
      if (k < d) return {1'b0, ~hp, ~vp, 2'b00};
      m  = k - d;
      h  = m % HT;
      v  = (m / HT) % VT;
      a  = (h < HACT) && (v < VACT);
      hs = (h >= HACT + HFP) && (h < HACT + HFP + HSW);
      vs = (v >= VACT + VFP) && (v < VACT + VFP + VSW);
      ln = (h == 0);
      fr = ln && (v == 0);
      return {a, hp ? hs : ~hs, vp ? vs : ~vs, ln, fr};
   endfunction

   task automatic check_dut(string nm, logic [24:0] got, int d, bit hp, bit vp);
      logic [24:0] exp;
      exp = {10'(n % HT), 10'((n / HT) % VT), model_sig(n, d, hp, vp)};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s n=%0d got=%h expected=%h", nm, n, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      check_dut({tag, "_d2"}, obs1, 2, 1'b0, 1'b0);
      check_dut({tag, "_d1p"}, obs2, 1, 1'b1, 1'b1);
   endtask

   task automatic check_lit(string nm, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_all("cyc");
         if (prev_ok && rst_n && !ce_last) begin
            n_checks++;
            if (obs1 !== prev1 || obs2 !== prev2) begin
               n_fail++;
               $display("FAIL freeze got=%h/%h expected=%h/%h", obs1, obs2, prev1, prev2);
            end
         end
         prev1   = obs1;
         prev2   = obs2;
         prev_ok = rst_n;
      end
   end

   int fq[$];
   int f2q[$];
   int hs_low, vs_low, act_hi, hs2_hi;
   bit found;

   initial begin
      rst_n = 1'b0;
      ce    = 1'b1;
      hs_low = 0; vs_low = 0; act_hi = 0; hs2_hi = 0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check_lit("rst_hsync_idle_d2", int'(hs1), 1);
      check_lit("rst_hsync_idle_pol1", int'(hs2), 0);
      #2 rst_n = 1'b1;

      // Free-running with ce=1: gather per-frame statistics for literal pins.
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         #1;
         if (fr1) fq.push_back(n);
         if (fr2) f2q.push_back(n);
         if (n >= 2 && n < 50) begin
            if (!hs1) hs_low++;
            if (!vs1) vs_low++;
            if (act1) act_hi++;
         end
         if (n >= 1 && n < 49 && hs2) hs2_hi++;
      end
      check_lit("frame_cnt", fq.size(), 3);
      if (fq.size() >= 3) begin
         check_lit("frame0_at", fq[0], 2);
         check_lit("frame1_at", fq[1], 50);
         check_lit("frame2_at", fq[2], 98);
      end
      check_lit("frame_d1_cnt", f2q.size(), 3);
      if (f2q.size() >= 1) check_lit("frame_d1_at", f2q[0], 1);
      check_lit("hsync_low_per_frame", hs_low, 12);
      check_lit("vsync_low_per_frame", vs_low, 8);
      check_lit("active_per_frame", act_hi, 12);
      check_lit("hsync_pol1_high", hs2_hi, 12);

      // Pseudo-random clock enable.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ce = 1'(($urandom_range(0, 1)));
      end

      // Mid-frame asynchronous reset at hcount=5, vcount=2.
      ce = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         #1;
         if (n % (HT * VT) == 2 * HT + 5) found = 1'b1;
      end
      check_lit("wait_mid_frame", int'(found), 1);
      #1 rst_n = 1'b0;
      #1;
      check_all("rst_async");
      check_lit("rst_async_hcount", int'(hc1), 0);
      check_lit("rst_async_active", int'(act1), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 60; i++) @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         ce = 1'(($urandom_range(0, 1)));
      end
      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter HACT, default 640, active pixels per line.
REQ-002 SHALL have parameter HFP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter HSW, default 96, hsync width in pixels.
REQ-004 SHALL have parameter HBP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter VACT, default 480, active lines per frame.
REQ-006 SHALL have parameter VFP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter VSW, default 2, vsync width in lines.
REQ-008 SHALL have parameter VBP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter HSPOL, default 0; 1 = hsync active-high, 0 = active-low.
REQ-010 SHALL have parameter VSPOL, default 0; same encoding as HSPOL, for vsync.
REQ-011 SHALL have parameter DELAY, default 1, range 1..8: output latency in enabled cycles.
REQ-012 SHALL have parameters XW, default 10, and YW, default 10: counter widths.
REQ-013 clk  input  1  pixel clock; single clock domain.
REQ-014 rst_n  input  1  asynchronous, active-low reset.
REQ-015 ce  input  1  pixel clock enable; all state advances only when ce=1.
REQ-016 hcount  output  XW  current horizontal position (undelayed).
REQ-017 vcount  output  YW  current line (undelayed).
REQ-018 active  output  1  data-enable, delayed by DELAY.
REQ-019 hsync  output  1  horizontal sync at HSPOL polarity, delayed by DELAY.
REQ-020 vsync  output  1  vertical sync at VSPOL polarity, delayed by DELAY.
REQ-021 line  output  1  one-enabled-cycle pulse at hcount==0, delayed by DELAY.
REQ-022 frame  output  1  one-enabled-cycle pulse at hcount==0 && vcount==0, delayed by DELAY.

Function
REQ-023 SHALL define HTOT=HACT+HFP+HSW+HBP and VTOT=VACT+VFP+VSW+VBP.
REQ-024 On ce=1, hcount SHALL increment; at hcount==HTOT-1 it SHALL wrap to 0.
REQ-025 vcount SHALL increment only on an hcount wrap; at vcount==VTOT-1 with an hcount wrap, it SHALL wrap to 0.
REQ-026 Raw active SHALL be (hcount<HACT)&&(vcount<VACT).
REQ-027 Raw hsync SHALL be asserted for HACT+HFP <= hcount < HACT+HFP+HSW.
REQ-028 Raw vsync SHALL be asserted for VACT+VFP <= vcount < VACT+VFP+VSW; it changes only at hcount==0.
REQ-029 Raw line and frame SHALL be decoded from the current counter state per REQ-021/REQ-022.
REQ-030 Raw signals SHALL pass through a DELAY-stage register pipeline; outputs at enabled cycle t SHALL reflect counters at enabled cycle t-DELAY.
REQ-031 When ce=0, counters and pipeline SHALL hold, and all outputs SHALL be stable.
REQ-032 The sync polarity inversion SHALL be applied at the output only; deasserted hsync = !HSPOL, deasserted vsync = !VSPOL.
REQ-033 Arithmetic SHALL be unsigned; HTOT <= 2^XW and VTOT <= 2^YW SHALL hold; every parameter SHALL be >= 1. Violations SHALL be a synthesis/elaboration error.

Reset
REQ-034 While rst_n=0: hcount=0, vcount=0, active=0, line=0, frame=0, hsync=!HSPOL, vsync=!VSPOL; all pipeline stages SHALL hold their inactive values.
REQ-035 Reset asserted mid-frame SHALL take effect immediately and asynchronously; deassertion SHALL restart at (0,0). The first frame pulse SHALL appear DELAY enabled cycles after release.

Verification (HACT=4,HFP=1,HSW=2,HBP=1,VACT=3,VFP=1,VSW=1,VBP=1,DELAY=2,ce=1: HTOT=8, VTOT=6, frame=48 cycles)
REQ-036 Release reset -> hcount steps 0..7 then 0; vcount increments once every 8 cycles; frame pulses at cycles 2, 50, 98.
REQ-037 Steady state -> hsync low for exactly 2 cycles per line, starting 2 cycles after hcount==5; active high for 4 cycles on each of lines 0..2, then low for lines 3..5.
REQ-038 Steady state -> vsync low for exactly 8 cycles per frame, while lines at vcount==4 are output; its edges coincide with line pulses.
REQ-039 Toggle ce 50% pseudo-random -> sequence identical to ce=1 when only ce=1 cycles are counted; outputs frozen on ce=0 cycles.
REQ-040 Assert rst_n=0 at hcount=5, vcount=2, then release -> outputs return to reset values at once; the counter sequence restarts from (0,0).
REQ-041 HSPOL=1, VSPOL=1, DELAY=1 -> syncs idle low and pulse high; frame appears 1 cycle after release.
